slot_monitor: RTL and testbench



---
 rtl/slot_monitor.sv | 134 +++++++++++++
 tb/tb_slot_monitor.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slot_monitor.sv
// Parking-slot occupancy monitor: per-slot arrival/departure edge detection, stay timing,
// live occupancy count, and a valid/ready event stream with lowest-slot-first arbitration.
module slot_monitor #(
    parameter int NSLOT = 8,
    parameter int DUR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NSLOT-1:0] de_swt,
    input  logic             tick,
    input  logic             ev_ready,
    output logic             ev_valid,
    output logic [2:0]       ev_slot,
    output logic             ev_arrive,
    output logic [DUR_W-1:0] ev_dur,
    output logic [3:0]       occ_cnt,
    output logic [3:0]       free_cnt,
    output logic             full,
    output logic             ev_drop
);

    localparam logic [DUR_W-1:0] DUR_MAX = {DUR_W{1'b1}};

    logic [NSLOT-1:0] occ;
    logic [NSLOT-1:0] rise;
    logic [NSLOT-1:0] fall;
    logic [NSLOT-1:0] pend_arr;
    logic [NSLOT-1:0] pend_dep;
    logic [NSLOT-1:0] clr_arr;
    logic [NSLOT-1:0] clr_dep;
    logic [DUR_W-1:0] dur  [NSLOT];
    logic [DUR_W-1:0] dlat [NSLOT];

    logic       load;
    logic       sel_found;
    logic [2:0] sel_idx;

    function automatic logic [3:0] popcount(input logic [NSLOT-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NSLOT; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    assign rise = de_swt & ~occ;
    assign fall = ~de_swt & occ;
    assign load = !ev_valid || ev_ready;

    // Priority pick: scanning downwards leaves the lowest pending slot selected.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (pend_arr[i] || pend_dep[i]) begin
                sel_found = 1'b1;
                sel_idx   = 3'(i);
            end
        end
    end

    // An arrival is always drained before the same slot's departure.
    always_comb begin
        clr_arr = '0;
        clr_dep = '0;
        if (load && sel_found) begin
            if (pend_arr[sel_idx]) clr_arr[sel_idx] = 1'b1;
            else                   clr_dep[sel_idx] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ      <= '0;
            occ_cnt  <= '0;
            pend_arr <= '0;
            pend_dep <= '0;
            ev_drop  <= 1'b0;
        end else begin
            occ      <= de_swt;
            occ_cnt  <= popcount(occ);
            // A set landing on a bit being cleared this cycle wins, keeping the event pending.
            pend_arr <= (pend_arr & ~clr_arr) | rise;
            pend_dep <= (pend_dep & ~clr_dep) | fall;
            if (|(rise & pend_arr) || |(fall & pend_dep)) begin
                ev_drop <= 1'b1;
            end
        end
    end

    // NOTE: the per-slot timer arrays are small and must read zero after reset, so they are reset explicitly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSLOT; i++) begin
                dur[i]  <= '0;
                dlat[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                if (fall[i]) dlat[i] <= dur[i];
                if (rise[i]) begin
                    dur[i] <= '0;
                end else if (occ[i] && tick && dur[i] != DUR_MAX) begin
                    dur[i] <= dur[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_valid  <= 1'b0;
            ev_slot   <= '0;
            ev_arrive <= 1'b0;
            ev_dur    <= '0;
        end else if (load) begin
            if (sel_found) begin
                ev_valid  <= 1'b1;
                ev_slot   <= sel_idx;
                ev_arrive <= pend_arr[sel_idx];
                ev_dur    <= pend_arr[sel_idx] ? '0 : dlat[sel_idx];
            end else begin
                ev_valid  <= 1'b0;
            end
        end
    end

    assign free_cnt = 4'(NSLOT) - occ_cnt;
    assign full     = (occ_cnt == 4'(NSLOT));

endmodule

// File: tb/tb_slot_monitor.sv
// Self-checking bench for slot_monitor: an event-level reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_slot_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] de_swt;
    logic       tick;
    logic       ev_ready;
    logic       ev_valid;
    logic [2:0] ev_slot;
    logic       ev_arrive;
    logic [7:0] ev_dur;
    logic [3:0] occ_cnt;
    logic [3:0] free_cnt;
    logic       full;
    logic       ev_drop;

    int vectors     = 0;
    int miscompares = 0;
    bit armed       = 0;

    slot_monitor #(.NSLOT(8), .DUR_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .de_swt   (de_swt),
        .tick     (tick),
        .ev_ready (ev_ready),
        .ev_valid (ev_valid),
        .ev_slot  (ev_slot),
        .ev_arrive(ev_arrive),
        .ev_dur   (ev_dur),
        .occ_cnt  (occ_cnt),
        .free_cnt (free_cnt),
        .full     (full),
        .ev_drop  (ev_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: slot occupancy, stay timers and a pending set per slot, one event slot out.
    bit m_occ  [8];
    int m_dur  [8];
    int m_dlat [8];
    bit m_parr [8];
    bit m_pdep [8];
    bit m_v;
    int m_slot;
    bit m_arr;
    int m_evdur;
    int m_cnt;
    bit m_drop;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_occ[i] = 0; m_dur[i] = 0; m_dlat[i] = 0; m_parr[i] = 0; m_pdep[i] = 0;
        end
        m_v = 0; m_slot = 0; m_arr = 0; m_evdur = 0; m_cnt = 0; m_drop = 0;
    endtask

    task automatic model_step();
        bit arrived [8];
        bit left    [8];
        int sel = -1;
        int cnt = 0;
        for (int i = 0; i < 8; i++) begin
            arrived[i] = de_swt[i] && !m_occ[i];
            left[i]    = !de_swt[i] && m_occ[i];
            if (m_occ[i]) cnt++;
            if ((arrived[i] && m_parr[i]) || (left[i] && m_pdep[i])) m_drop = 1;
        end
        if (!m_v || ev_ready) begin
            for (int i = 0; i < 8; i++) begin
                if (sel < 0 && (m_parr[i] || m_pdep[i])) sel = i;
            end
            if (sel >= 0) begin
                m_v = 1; m_slot = sel;
                if (m_parr[sel]) begin
                    m_arr = 1; m_evdur = 0; m_parr[sel] = 0;
                end else begin
                    m_arr = 0; m_evdur = m_dlat[sel]; m_pdep[sel] = 0;
                end
            end else begin
                m_v = 0;
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (left[i]) begin
                m_pdep[i] = 1;
                m_dlat[i] = m_dur[i];
            end
            if (arrived[i]) begin
                m_parr[i] = 1;
                m_dur[i]  = 0;
            end else if (m_occ[i] && tick) begin
                m_dur[i] = (m_dur[i] >= 255) ? 255 : m_dur[i] + 1;
            end
            m_occ[i] = de_swt[i];
        end
        m_cnt = cnt;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    always @(negedge clk) begin
        if (armed) begin
            check("valid", ev_valid, m_v);
            if (m_v) begin
                check("slot", ev_slot, m_slot);
                check("arrive", ev_arrive, m_arr);
                check("dur", ev_dur, m_evdur);
            end
            check("occ_cnt", occ_cnt, m_cnt);
            check("free_cnt", free_cnt, 8 - m_cnt);
            check("full", full, m_cnt == 8);
            check("drop", ev_drop, m_drop);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input string name, input int slot, input bit arrive, input int dur,
                             input int budget);
        bit seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (ev_valid && ev_ready) begin
                seen = 1;
                check({name, "_slot"}, ev_slot, slot);
                check({name, "_arrive"}, ev_arrive, arrive);
                check({name, "_dur"}, ev_dur, dur);
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got no event within %0d cycles, expected slot %0d", name, budget, slot);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, ev_valid, 0);
        check({tag, "_slot"}, ev_slot, 0);
        check({tag, "_arrive"}, ev_arrive, 0);
        check({tag, "_dur"}, ev_dur, 0);
        check({tag, "_occ"}, occ_cnt, 0);
        check({tag, "_free"}, free_cnt, 8);
        check({tag, "_full"}, full, 0);
        check({tag, "_drop"}, ev_drop, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        de_swt = 8'h00; tick = 1'b0; ev_ready = 1'b1;
        step(3);
        check_reset_outputs("rst0");
        rst = 1'b0;
        armed = 1;

        // Single stay on slot 3 lasting 5 ticks.
        step(2);
        de_swt = 8'h08;
        expect_ev("s1_arr3", 3, 1'b1, 0, 4);
        check("s1_occ1", occ_cnt, 1);
        step(1);
        repeat (5) begin
            tick = 1'b1; step(1);
            tick = 1'b0; step(1);
        end
        de_swt = 8'h00;
        expect_ev("s1_dep3", 3, 1'b0, 5, 4);
        check("s1_occ0", occ_cnt, 0);

        // All slots fill at once: eight back-to-back arrivals.
        step(1);
        de_swt = 8'hFF;
        expect_ev("s2_arr0", 0, 1'b1, 0, 4);
        for (int s = 1; s < 8; s++) expect_ev("s2_arr", s, 1'b1, 0, 1);
        check("s2_occ8", occ_cnt, 8);
        check("s2_full", full, 1);

        // Stalled consumer with three arrivals queued.
        step(1);
        de_swt = 8'h00;
        step(12);
        ev_ready = 1'b0;
        de_swt = 8'h07;
        step(5);
        check("s3_hold_valid", ev_valid, 1);
        check("s3_hold_slot", ev_slot, 0);
        check("s3_hold_arr", ev_arrive, 1);
        step(3);
        check("s3_stable_valid", ev_valid, 1);
        check("s3_stable_slot", ev_slot, 0);
        check("s3_stable_arr", ev_arrive, 1);
        ev_ready = 1'b1;
        expect_ev("s3_a0", 0, 1'b1, 0, 1);
        expect_ev("s3_a1", 1, 1'b1, 0, 1);
        expect_ev("s3_a2", 2, 1'b1, 0, 1);
        @(negedge clk);
        check("s3_idle", ev_valid, 0);

        // Long stay on slot 7 saturates the timer.
        step(1);
        de_swt = 8'h87;
        expect_ev("s4_arr7", 7, 1'b1, 0, 4);
        step(1);
        tick = 1'b1;
        step(300);
        tick = 1'b0;
        de_swt = 8'h07;
        expect_ev("s4_dep7", 7, 1'b0, 255, 4);

        // Slot 2 toggles twice behind a stalled consumer: second departure overwrites the first.
        step(1);
        de_swt = 8'h03;
        expect_ev("s5_dep2", 2, 1'b0, 255, 4);
        step(1);
        ev_ready = 1'b0;
        de_swt = 8'h07;
        step(1);
        tick = 1'b1; step(2);
        tick = 1'b0; de_swt = 8'h03;
        step(2);
        de_swt = 8'h07;
        step(1);
        tick = 1'b1; step(4);
        tick = 1'b0; de_swt = 8'h03;
        step(3);
        check("s5_drop", ev_drop, 1);
        ev_ready = 1'b1;
        expect_ev("s5_arr_a", 2, 1'b1, 0, 1);
        expect_ev("s5_arr_b", 2, 1'b1, 0, 1);
        expect_ev("s5_dep", 2, 1'b0, 4, 1);

        // Reset asserted mid-operation with events pending.
        step(1);
        ev_ready = 1'b0;
        de_swt = 8'h05;
        step(3);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst1");
        step(2);
        rst = 1'b0;
        ev_ready = 1'b1;
        expect_ev("s6_arr0", 0, 1'b1, 0, 4);
        check("s6_occ2", occ_cnt, 2);
        expect_ev("s6_arr2", 2, 1'b1, 0, 1);

        // Randomized soak against the model.
        for (int n = 0; n < 3000; n++) begin
            step(1);
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(15) == 0) de_swt[b] = ~de_swt[b];
            end
            tick     = ($urandom_range(3) == 0);
            ev_ready = ($urandom_range(3) != 0);
            if (n >= 1500 && n < 1600) ev_ready = 1'b0;
            if (n == 2500) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        ev_ready = 1'b1;
        step(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
